// File: rtl/muldiv_ctrl.sv
// Multiply/divide unit sequencer: HI/LO registers, fixed-latency RUN timing and pipeline stall.
// Optional MADD (op 6) is enabled by defining MULDIV_CTRL_MADD_EN.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;

`ifdef MULDIV_CTRL_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] pend;
  logic        pend_wr;
`ifdef MULDIV_CTRL_MADD_EN
  logic        pend_madd;
`endif

  logic        long_op;
  logic [63:0] sa64, sb64, prod_s, prod_u;
  logic        b_nz, ovf;
  logic [31:0] dsor_s, dsor_u, q_s, r_s, q_u, r_u;

  assign long_op = (md_op <= OP_DIVU) || ((md_op == OP_MADD) && MADD_EN);
  assign stall   = md_use_d & (busy | (md_start & long_op));

  assign sa64   = {{32{md_a[31]}}, md_a};
  assign sb64   = {{32{md_b[31]}}, md_b};
  assign prod_s = sa64 * sb64;
  assign prod_u = {32'd0, md_a} * {32'd0, md_b};

  // Divisors are forced to 1 when the real result is either special-cased or discarded.
  assign b_nz   = (md_b != 32'd0);
  assign ovf    = (md_a == 32'h8000_0000) && (md_b == 32'hFFFF_FFFF);
  assign dsor_s = (b_nz && !ovf) ? md_b : 32'd1;
  assign dsor_u = b_nz ? md_b : 32'd1;
  assign q_s    = ovf ? 32'h8000_0000 : 32'($signed(md_a) / $signed(dsor_s));
  assign r_s    = ovf ? 32'd0 : 32'($signed(md_a) % $signed(dsor_s));
  assign q_u    = md_a / dsor_u;
  assign r_u    = md_a % dsor_u;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend    <= 64'd0;
      pend_wr <= 1'b0;
`ifdef MULDIV_CTRL_MADD_EN
      pend_madd <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
`ifdef MULDIV_CTRL_MADD_EN
            pend_madd <= 1'b0;
`endif
            case (md_op)
              OP_MULT:  begin pend <= prod_s;     pend_wr <= 1'b1; cnt <= 4'd4; state <= RUN; busy <= 1'b1; end
              OP_MULTU: begin pend <= prod_u;     pend_wr <= 1'b1; cnt <= 4'd4; state <= RUN; busy <= 1'b1; end
              OP_DIV:   begin pend <= {r_s, q_s}; pend_wr <= b_nz; cnt <= 4'd9; state <= RUN; busy <= 1'b1; end
              OP_DIVU:  begin pend <= {r_u, q_u}; pend_wr <= b_nz; cnt <= 4'd9; state <= RUN; busy <= 1'b1; end
              OP_MTHI:  hi <= md_a;
              OP_MTLO:  lo <= md_a;
`ifdef MULDIV_CTRL_MADD_EN
              OP_MADD:  begin
                pend <= prod_s; pend_wr <= 1'b1; pend_madd <= 1'b1;
                cnt <= 4'd4; state <= RUN; busy <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (pend_wr) begin
`ifdef MULDIV_CTRL_MADD_EN
              // Accumulate onto the HI/LO value present at commit, not at start.
              if (pend_madd) {hi, lo} <= {hi, lo} + pend;
              else           {hi, lo} <= pend;
`else
              {hi, lo} <= pend;
`endif
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-002 The port clk SHALL be: input, 1 bit, system clock; all state updates on its rising edge.
REQ-003 The port reset SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 The port md_start SHALL be: input, 1 bit, E-stage MDU instruction valid this cycle.
REQ-005 The port md_op SHALL be: input, 3 bits, 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 reserved.
REQ-006 The ports md_a and md_b SHALL be: input, 32 bits each, rs and rt operand values from E stage.
REQ-007 The port md_use_d SHALL be: input, 1 bit, D-stage instruction is MULT/DIV/MFHI/MFLO/MTHI/MTLO/MADD.
REQ-008 The port busy SHALL be: output, 1 bit, an operation is in progress.
REQ-009 The port stall SHALL be: output, 1 bit, freeze the F and D stages and insert a bubble into E.
REQ-010 The ports hi and lo SHALL be: output, 32 bits each, architectural HI/LO registers, read by MFHI/MFLO in E.

Function
REQ-011 The block SHALL have two states, IDLE and RUN, with a 4-bit down-counter cnt.
- IDLE -> RUN: md_start=1 and md_op in {0,1,2,3,6}.
- Load cnt with L-1, where L = 5 for MULT/MULTU/MADD and L = 10 for DIV/DIVU.
REQ-012 In RUN, cnt SHALL decrement every cycle; at the edge where cnt==0, hi/lo SHALL commit the pending result and the state SHALL return to IDLE.
REQ-013 Timing SHALL be as follows for a start sampled at edge N:
- busy=1 during cycles N+1..N+L;
- hi/lo SHALL change at edge N+L;
- busy=0 after edge N+L.
REQ-014 The result SHALL be computed from operands latched at edge N into pending registers; operand changes after edge N SHALL have no effect.
REQ-015 MULT SHALL produce signed 64-bit {hi,lo} = a*b; MULTU SHALL produce the unsigned product.
REQ-016 DIV SHALL set lo = signed quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-017 For DIV, 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0.
REQ-018 DIVU SHALL produce the unsigned quotient and remainder.
REQ-019 Divide by zero SHALL still run the full L=10 cycles with busy asserted; hi/lo SHALL be unchanged at completion.
REQ-020 MTHI/MTLO with md_start=1 in IDLE SHALL write hi (or lo) with md_a at the next edge, with no busy and no RUN.
REQ-021 md_start while in RUN SHALL be ignored: the operation in flight SHALL continue and hi/lo SHALL not be disturbed.
REQ-022 md_op=7, and md_op=6 when MADD is disabled, SHALL be a no-op.
REQ-023 stall SHALL equal md_use_d & (busy | (md_start & md_op in {0,1,2,3,6})) and SHALL be combinational.
REQ-024 hi and lo SHALL be registered outputs.

Reset
REQ-025 When reset=1 at an edge, the block SHALL go to IDLE with cnt=0, busy=0, hi=0, lo=0 and the pending result cleared.
REQ-026 Reset SHALL take priority over md_start.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no commit.
REQ-028 stall SHALL be 0 in the cycle after reset unless md_use_d=1 together with a start.

Configuration
REQ-029 When macro MULDIV_CTRL_MADD_EN is defined, op 6 (MADD) SHALL compute {hi,lo} = {hi,lo} + signed(a*b) modulo 2^64, with L=5.
REQ-030 The MADD accumulator SHALL use the hi/lo value at commit time.
REQ-031 When MULDIV_CTRL_MADD_EN is not defined, op 6 SHALL be a no-op and SHALL never assert busy or stall.

Verification
REQ-032 MULT a=0xFFFFFFFE, b=3 at edge N -> busy=1 for 5 cycles; at edge N+5, hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles, lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU a=7, b=0 -> busy for 10 cycles, hi/lo unchanged.
REQ-034 MULTU a=0x10, b=0x10 started; md_use_d=1 throughout -> stall=1 in the start cycle and in cycles N+1..N+5, 0 afterwards; a second md_start issued in RUN -> ignored.
REQ-035 MTLO a=0x12345678 -> lo=0x12345678 after one edge, busy stays 0; DIV started, then reset asserted at cycle N+4 -> hi=lo=0 and busy=0 after that edge, with no later commit.
REQ-036 With MULDIV_CTRL_MADD_EN: hi=0, lo=0xFFFFFFFF, MADD a=1, b=1 -> after 5 cycles, hi=1 and lo=0. Without the macro, the same stimulus -> busy=0, stall=0, hi/lo unchanged.
